// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback front end.
package regfile_pkg;

  localparam int unsigned ADDRESS_WIDTH = 5;
  localparam int unsigned DATA_WIDTH    = 32;

  typedef logic [ADDRESS_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]    reg_data_t;

  // One pending register write: destination index plus data.
  typedef struct packed {
    reg_idx_t  addr;
    reg_data_t data;
  } wb_req_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests.
// Ports: clk, rst_n (async active-low), push/push_data (enqueue),
//        pop (dequeue head), head (current oldest entry), count (occupancy).
module wb_fifo
  import regfile_pkg::wb_req_t;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_req_t                    push_data,
  input  logic                       pop,
  output wb_req_t                    head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push && (count < CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Merges execute (A) and load (B) writebacks onto the single register-file
// write port. A has strict priority; B is buffered in a FIFO. A pending-load
// scoreboard (busy) tracks registers awaiting load writeback.
// Ports: clk, rst_n; a_valid/a_addr/a_data (source A); b_issue/b_issue_addr
//        (mark load pending); b_valid/b_ready/b_addr/b_data (source B);
//        we3/ad3/wd3 (registered write port); busy (pending mask);
//        fifo_count (B buffer occupancy).
module regfile_wb_queue
  import regfile_pkg::wb_req_t;
  import regfile_pkg::REG_ZERO;
#(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          a_valid,
  input  logic [ADDRESS_WIDTH-1:0]      a_addr,
  input  logic [DATA_WIDTH-1:0]         a_data,
  input  logic                          b_issue,
  input  logic [ADDRESS_WIDTH-1:0]      b_issue_addr,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [ADDRESS_WIDTH-1:0]      b_addr,
  input  logic [DATA_WIDTH-1:0]         b_data,
  output logic                          we3,
  output logic [ADDRESS_WIDTH-1:0]      ad3,
  output logic [DATA_WIDTH-1:0]         wd3,
  output logic [2**ADDRESS_WIDTH-1:0]   busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned NREG = 2**ADDRESS_WIDTH;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  wb_req_t           push_req;
  wb_req_t           head;
  logic              push;
  logic              pop;
  logic [NREG-1:0]   busy_next;

  assign push_req = '{addr: b_addr, data: b_data};

  // Ready comes from registered occupancy only, so a full FIFO stays
  // non-ready in the cycle it dequeues.
  assign b_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign push    = b_valid && b_ready;
  assign pop     = !a_valid && (fifo_count != '0);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // Write-port register: x0 writes are selected (and dequeued) but not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      ad3 <= '0;
      wd3 <= '0;
    end else if (a_valid) begin
      we3 <= (a_addr != REG_ZERO);
      ad3 <= a_addr;
      wd3 <= a_data;
    end else if (pop) begin
      we3 <= (head.addr != REG_ZERO);
      ad3 <= head.addr;
      wd3 <= head.data;
    end else begin
      we3 <= 1'b0;
    end
  end

  // Scoreboard update; the set is applied last so it wins a same-bit collision.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head.addr] = 1'b0;
    if (b_issue && (b_issue_addr != REG_ZERO)) busy_next[b_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule
